branch_ctrl_fsm: RTL and testbench
==================================

// Module: branch_ctrl_fsm
// PURPOSE
//  Control-unit sub-FSM that sequences conditional branches (BEQ/BNE/BLE/BGT) in the multicycle CPU.
//  - Drives the branch-condition evaluator: uc_control, uc_op.
//  - Consumes its cond_true result and issues register loads, ALU subtract, PC write and PC source select.
//  - The main control FSM hands off via start/opcode and resumes on done.
// PARAMETERS
//  OP_BEQ   6'h04  opcode selecting BEQ (uc_op 2'b00)
//  OP_BNE   6'h05  opcode selecting BNE (uc_op 2'b01)
//  OP_BLE   6'h06  opcode selecting BLE (uc_op 2'b10)
//  OP_BGT   6'h07  opcode selecting BGT (uc_op 2'b11)
//  ALU_SUB  3'b010 ALU op code for subtraction (A-B), generates igual/maior
//  ALU_NOP  3'b000 ALU op code driven when idle
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  reset       in   1  synchronous, active-high
//  start       in   1  one-cycle request from main FSM; sampled only in IDLE
//  opcode      in   6  instruction opcode, captured when start accepted
//  cond_true   in   1  branch-condition result from evaluator (valid in EVAL)
//  a_load      out  1  load register A from rs
//  b_load      out  1  load register B from rt
//  alu_op      out  3  ALU operation select
//  uc_control  out  1  enable to condition evaluator
//  uc_op       out  2  condition select to evaluator
//  pc_write    out  1  write PC (taken branch only)
//  pc_src      out  1  1 = branch target (ALUOut), 0 = PC+4 path
//  busy        out  1  high in every state except IDLE
//  done        out  1  one-cycle pulse, branch sequence finished
//  illegal     out  1  one-cycle pulse, start with non-branch opcode
// BEHAVIOUR
//  Reset (sync): state=IDLE, op_reg=0, taken_reg=0.
//   All outputs low except alu_op=ALU_NOP and uc_op=2'b00.
//  States: IDLE -> LOAD -> EVAL -> DECIDE -> (WRITE) -> FINISH -> IDLE.
//  IDLE: busy=0. On start:
//   - opcode in OP_BEQ..OP_BGT: capture op_reg = opcode-OP_BEQ (2 bits), go LOAD.
//   - otherwise: pulse illegal in the next cycle, stay IDLE.
//  LOAD: a_load=1, b_load=1 for exactly one cycle -> EVAL.
//  EVAL: alu_op=ALU_SUB, uc_control=1, uc_op=op_reg.
//   - cond_true sampled into taken_reg at the end of this cycle -> DECIDE.
//  DECIDE: alu_op=ALU_SUB held, uc_control=0.
//   - taken_reg=1 -> WRITE; else -> FINISH.
//  WRITE: pc_write=1, pc_src=1 for exactly one cycle -> FINISH.
//  FINISH: done=1 for one cycle -> IDLE.
//  Latency start->done: 5 cycles taken, 4 cycles not taken.
//  Outputs are Moore (decoded from state/op_reg only); no combinational path from cond_true to outputs.
//  uc_op holds op_reg in all non-IDLE states; uc_control is high only in EVAL.
//  start while busy: ignored (no queuing, no illegal pulse).
//  opcode changes after acceptance: no effect (op_reg latched).
//  Reset mid-sequence: return to IDLE next edge.
//   - pc_write, done must not pulse after reset asserted, even from WRITE.
//  cond_true outside EVAL: ignored.
//  Unreachable state encodings: recover to IDLE.
// TESTING
//  1. reset 2 cycles -> all outputs 0, alu_op=000, busy=0; start ignored while reset=1.
//  2. start, opcode=6'h04, cond_true=1 in EVAL
//     -> uc_op=00, pc_write=1 on cycle 4, done on cycle 5.
//  3. start, opcode=6'h05, cond_true=0 in EVAL
//     -> uc_op=01, pc_write never high, done on cycle 4.
//  4. opcode=6'h07 with cond_true=1 except in EVAL cycle (=0)
//     -> not taken; opcode=6'h06 cond_true=1 -> taken.
//  5. start, opcode=6'h23 -> illegal pulse 1 cycle, busy stays 0, no a_load.
//  6. reset asserted in WRITE -> pc_write low next cycle, no done; start opcode=6'h04 repeat -> completes normally.

Source files
------------

// File: rtl/branch_ctrl_fsm.sv
// Branch control sub-FSM for the multicycle CPU. It sequences BEQ/BNE/BLE/BGT:
// it loads the operands, runs the condition evaluator, decides, optionally
// writes the PC, then hands control back to the main FSM.
// Latency: start->done is 5 cycles when the branch is taken, 4 when not taken.
// Backpressure: none. A start that arrives while busy is dropped without an
// illegal pulse.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   start, opcode        handoff from the main FSM (start is sampled in IDLE only)
//   cond_true            evaluator result, sampled only in EVAL
//   a_load, b_load       operand register loads
//   alu_op               ALU operation select
//   uc_control, uc_op    condition evaluator enable and condition select
//   pc_write, pc_src     PC write enable and PC source select (1 = branch target)
//   busy, done, illegal  status flags; done and illegal are one-cycle pulses
module branch_ctrl_fsm #(
  parameter logic [5:0] OP_BEQ  = 6'h04,
  parameter logic [5:0] OP_BNE  = 6'h05,
  parameter logic [5:0] OP_BLE  = 6'h06,
  parameter logic [5:0] OP_BGT  = 6'h07,
  parameter logic [2:0] ALU_SUB = 3'b010,
  parameter logic [2:0] ALU_NOP = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic       cond_true,
  output logic       a_load,
  output logic       b_load,
  output logic [2:0] alu_op,
  output logic       uc_control,
  output logic [1:0] uc_op,
  output logic       pc_write,
  output logic       pc_src,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_EVAL   = 3'd2,
    S_DECIDE = 3'd3,
    S_WRITE  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t     state;
  logic [1:0] op_reg;
  logic       taken_reg;

  // Decode the incoming opcode into a branch flag and an evaluator condition select.
  logic       is_branch;
  logic [1:0] op_sel;

  always_comb begin
    is_branch = 1'b1;
    op_sel    = 2'b00;
    case (opcode)
      OP_BEQ:  op_sel = 2'b00;
      OP_BNE:  op_sel = 2'b01;
      OP_BLE:  op_sel = 2'b10;
      OP_BGT:  op_sel = 2'b11;
      default: is_branch = 1'b0;
    endcase
  end

  // The outputs are registered. Each one is loaded with the Moore value of the
  // state being entered, so it is a pure function of state/op_reg and never
  // depends combinationally on cond_true.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_reg     <= 2'b00;
      taken_reg  <= 1'b0;
      a_load     <= 1'b0;
      b_load     <= 1'b0;
      alu_op     <= ALU_NOP;
      uc_control <= 1'b0;
      uc_op      <= 2'b00;
      pc_write   <= 1'b0;
      pc_src     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      // Defaults describe a generic busy state; each arm overrides them as needed.
      a_load     <= 1'b0;
      b_load     <= 1'b0;
      alu_op     <= ALU_NOP;
      uc_control <= 1'b0;
      uc_op      <= op_reg;
      pc_write   <= 1'b0;
      pc_src     <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      illegal    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start && is_branch) begin
            op_reg <= op_sel;
            uc_op  <= op_sel;
            a_load <= 1'b1;
            b_load <= 1'b1;
            state  <= S_LOAD;
          end else begin
            busy    <= 1'b0;
            uc_op   <= 2'b00;
            illegal <= start;
          end
        end

        S_LOAD: begin
          alu_op     <= ALU_SUB;
          uc_control <= 1'b1;
          state      <= S_EVAL;
        end

        S_EVAL: begin
          // Only this state captures the evaluator result.
          taken_reg <= cond_true;
          alu_op    <= ALU_SUB;
          state     <= S_DECIDE;
        end

        S_DECIDE: begin
          if (taken_reg) begin
            pc_write <= 1'b1;
            pc_src   <= 1'b1;
            state    <= S_WRITE;
          end else begin
            done  <= 1'b1;
            state <= S_FINISH;
          end
        end

        S_WRITE: begin
          done  <= 1'b1;
          state <= S_FINISH;
        end

        S_FINISH: begin
          busy  <= 1'b0;
          uc_op <= 2'b00;
          state <= S_IDLE;
        end

        default: begin
          // Unused encodings fall back to an idle-looking state.
          busy  <= 1'b0;
          uc_op <= 2'b00;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl_fsm.sv
module tb_branch_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] opcode;
  logic       cond_true;
  logic       a_load, b_load, uc_control, pc_write, pc_src, busy, done, illegal;
  logic [2:0] alu_op;
  logic [1:0] uc_op;

  int checks = 0;
  int errors = 0;

  branch_ctrl_fsm dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .cond_true(cond_true),
    .a_load(a_load), .b_load(b_load), .alu_op(alu_op), .uc_control(uc_control),
    .uc_op(uc_op), .pc_write(pc_write), .pc_src(pc_src), .busy(busy),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Packed output word: {a_load,b_load,alu_op[2:0],uc_control,uc_op[1:0],pc_write,pc_src,busy,done,illegal}
  logic [12:0] act;
  assign act = {a_load, b_load, alu_op, uc_control, uc_op, pc_write, pc_src, busy, done, illegal};

  typedef struct {
    int          grp;
    logic        rst;
    logic        st;
    logic [5:0]  op;
    logic        cond;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] o(input logic al, input logic bl, input logic [2:0] alu,
                                    input logic ucc, input logic [1:0] uop, input logic pw,
                                    input logic ps, input logic bz, input logic dn, input logic il);
    return {al, bl, alu, ucc, uop, pw, ps, bz, dn, il};
  endfunction

  function automatic logic [12:0] o_idle();                   return o(0,0,3'b000,0,2'b00,0,0,0,0,0); endfunction
  function automatic logic [12:0] o_ill();                    return o(0,0,3'b000,0,2'b00,0,0,0,0,1); endfunction
  function automatic logic [12:0] o_load(input logic [1:0] u); return o(1,1,3'b000,0,u,0,0,1,0,0);     endfunction
  function automatic logic [12:0] o_eval(input logic [1:0] u); return o(0,0,3'b010,1,u,0,0,1,0,0);     endfunction
  function automatic logic [12:0] o_dec(input logic [1:0] u);  return o(0,0,3'b010,0,u,0,0,1,0,0);     endfunction
  function automatic logic [12:0] o_wr(input logic [1:0] u);   return o(0,0,3'b000,0,u,1,1,1,0,0);     endfunction
  function automatic logic [12:0] o_fin(input logic [1:0] u);  return o(0,0,3'b000,0,u,0,0,1,1,0);     endfunction

  task automatic add(input int g, input logic r, input logic s, input logic [5:0] op,
                     input logic c, input logic [12:0] e);
    vec_t v;
    v.grp = g; v.rst = r; v.st = s; v.op = op; v.cond = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  n;
  int  lat;
  logic seen_pw;

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 6'h00; cond_true = 1'b0;

    // 1: reset, with start held high to show it is ignored
    add(1, 1, 1, 6'h04, 0, o_idle());
    add(1, 1, 1, 6'h04, 0, o_idle());
    add(1, 0, 0, 6'h00, 0, o_idle());
    // 2: BEQ taken; cond_true is high only in EVAL
    add(2, 0, 1, 6'h04, 0, o_load(2'b00));
    add(2, 0, 0, 6'h04, 0, o_eval(2'b00));
    add(2, 0, 0, 6'h04, 1, o_dec(2'b00));
    add(2, 0, 0, 6'h04, 0, o_wr(2'b00));
    add(2, 0, 0, 6'h04, 0, o_fin(2'b00));
    add(2, 0, 0, 6'h04, 0, o_idle());
    // 3: BNE not taken; start arrives while busy and opcode changes after acceptance
    add(3, 0, 1, 6'h05, 0, o_load(2'b01));
    add(3, 0, 1, 6'h23, 0, o_eval(2'b01));
    add(3, 0, 1, 6'h07, 0, o_dec(2'b01));
    add(3, 0, 0, 6'h07, 0, o_fin(2'b01));
    add(3, 0, 0, 6'h00, 0, o_idle());
    // 4a: BGT with cond_true high everywhere except EVAL, so not taken
    add(4, 0, 1, 6'h07, 1, o_load(2'b11));
    add(4, 0, 0, 6'h07, 1, o_eval(2'b11));
    add(4, 0, 0, 6'h07, 0, o_dec(2'b11));
    add(4, 0, 0, 6'h07, 1, o_fin(2'b11));
    add(4, 0, 0, 6'h07, 1, o_idle());
    // 4b: BLE with cond_true high, so taken
    add(4, 0, 1, 6'h06, 1, o_load(2'b10));
    add(4, 0, 0, 6'h06, 1, o_eval(2'b10));
    add(4, 0, 0, 6'h06, 1, o_dec(2'b10));
    add(4, 0, 0, 6'h06, 1, o_wr(2'b10));
    add(4, 0, 0, 6'h06, 1, o_fin(2'b10));
    add(4, 0, 0, 6'h06, 0, o_idle());
    // 5: non-branch opcode gives a one-cycle illegal pulse and stays idle; opcodes 0x03 and 0x08 sit just outside the branch range
    add(5, 0, 1, 6'h23, 0, o_ill());
    add(5, 0, 0, 6'h23, 0, o_idle());
    add(5, 0, 1, 6'h03, 0, o_ill());
    add(5, 0, 1, 6'h08, 0, o_ill());
    add(5, 0, 0, 6'h00, 0, o_idle());

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      start     = vecs[i].st;
      opcode    = vecs[i].op;
      cond_true = vecs[i].cond;
      tick();
      checks++;
      if (act !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d(t%0d): outputs got 0x%04h, expected 0x%04h",
                 i, vecs[i].grp, act, vecs[i].exp);
      end
    end

    // 6: reset asserted while in WRITE, then a normal BEQ
    reset = 0; start = 1; opcode = 6'h04; cond_true = 1;
    tick();
    start = 0;
    n = 0;
    while (!pc_write && n < 10) begin
      tick();
      n++;
    end
    check("t6_reach_write", {31'd0, pc_write}, 32'd1);
    check("t6_write_cycles", n, 3);
    reset = 1;
    tick();
    check("t6_rst_pc_write", {31'd0, pc_write}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    reset = 0;
    tick();
    check("t6_after_rst_idle", {19'd0, act}, {19'd0, o_idle()});

    start = 1; opcode = 6'h04; cond_true = 1;
    tick();
    start = 0;
    lat = 1;
    seen_pw = pc_write;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (pc_write) seen_pw = 1'b1;
    end
    check("t6_repeat_latency", lat, 5);
    check("t6_repeat_pc_write", {31'd0, seen_pw}, 32'd1);
    tick();
    check("t6_repeat_idle", {19'd0, act}, {19'd0, o_idle()});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
